// File: rtl/if_id_buf_pkg.sv
// Shared constants and types for the fetch/decode boundary buffer.
// Carries the CPU_BUS / INST_NOP / ZERO_WORD defines (guarded so a global defines file wins).
`ifndef CPU_BUS
`define CPU_BUS 32
`endif
`ifndef INST_NOP
`define INST_NOP 32'h00000013
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h00000000
`endif

package if_id_buf_pkg;

    localparam int          CPU_BUS   = `CPU_BUS;
    localparam logic [31:0] INST_NOP  = `INST_NOP;
    localparam logic [31:0] ZERO_WORD = `ZERO_WORD;

    // Occupancy encoded as {OUT.valid, SKID.valid}; 2'b01 cannot occur.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    function automatic state_t occupancy(input logic out_valid, input logic skid_valid);
        return state_t'({out_valid, skid_valid});
    endfunction

endpackage

// File: rtl/if_id_buf_if.sv
// Fetch-to-decode handshake bundle: upstream pair in, downstream pair out, valid/ready both ways.
// Handshake: a pair moves across a side on a rising edge where its valid and ready are both 1.
interface if_id_buf_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] instAddrIn;
    logic [DATA_W-1:0] instIn;
    logic              validIn;
    logic              readyOut;
    logic [DATA_W-1:0] instAddrOut;
    logic [DATA_W-1:0] instOut;
    logic              validOut;
    logic              readyIn;

    // The buffer itself.
    modport slave (
        input  instAddrIn, instIn, validIn, readyIn,
        output readyOut, instAddrOut, instOut, validOut
    );

    // Whoever drives fetch and plays decode (pipeline glue or a bench).
    modport master (
        output instAddrIn, instIn, validIn, readyIn,
        input  readyOut, instAddrOut, instOut, validOut
    );
endinterface

// File: rtl/if_id_entry.sv
// One {addr, inst, valid} slot of the IF/ID buffer; clear wins over load.
// A cleared slot holds a NOP at address zero so decode never sees stale bits.
import if_id_buf_pkg::*;

module if_id_entry #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_inst,
    output logic [DATA_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_inst,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_inst;
    logic              r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= DATA_W'(ZERO_WORD);
            r_inst  <= DATA_W'(INST_NOP);
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_addr  <= DATA_W'(ZERO_WORD);
            r_inst  <= DATA_W'(INST_NOP);
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_addr  <= i_addr;
            r_inst  <= i_inst;
            r_valid <= 1'b1;
        end
    end

    assign o_addr  = r_addr;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_id_buf.sv
// IF/ID pipeline register with a two-entry skid buffer (OUT + SKID) and synchronous flush.
// Optional stall/flush performance counters are built only when IF_ID_PERF_CNT_EN is defined.
import if_id_buf_pkg::*;

module if_id_buf #(
    parameter int DATA_W = CPU_BUS,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    if_id_buf_if.slave       bus,
    input  logic             flushIn,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt,
    output state_t           dbgState
);

    logic [DATA_W-1:0] w_out_addr;
    logic [DATA_W-1:0] w_out_inst;
    logic              w_out_valid;
    logic [DATA_W-1:0] w_skid_addr;
    logic [DATA_W-1:0] w_skid_inst;
    logic              w_skid_valid;

    logic              w_accept;
    logic              w_out_free;
    logic              w_out_load;
    logic              w_out_clear;
    logic              w_out_sel_skid;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic [DATA_W-1:0] w_out_addr_d;
    logic [DATA_W-1:0] w_out_inst_d;

    // readyOut comes straight from the SKID valid flop, so it never sees readyIn.
    assign bus.readyOut = !w_skid_valid;
    assign w_accept     = bus.validIn && !w_skid_valid;
    assign w_out_free   = !w_out_valid || bus.readyIn;

    always_comb begin
        w_out_load     = 1'b0;
        w_out_clear    = 1'b0;
        w_out_sel_skid = 1'b0;
        w_skid_load    = 1'b0;
        w_skid_clear   = 1'b0;
        if (flushIn) begin
            w_out_clear  = 1'b1;
            w_skid_clear = 1'b1;
        end else if (w_out_free) begin
            if (w_skid_valid) begin
                // readyOut is low whenever SKID is full, so no accept competes here.
                w_out_load     = 1'b1;
                w_out_sel_skid = 1'b1;
                w_skid_clear   = 1'b1;
            end else if (w_accept) begin
                w_out_load = 1'b1;
            end else begin
                w_out_clear = 1'b1;
            end
        end else if (w_accept) begin
            w_skid_load = 1'b1;
        end
    end

    assign w_out_addr_d = w_out_sel_skid ? w_skid_addr : bus.instAddrIn;
    assign w_out_inst_d = w_out_sel_skid ? w_skid_inst : bus.instIn;

    if_id_entry #(.DATA_W(DATA_W)) u_out (
        .clk     (clk),
        .rst_n   (rst),
        .i_load  (w_out_load),
        .i_clear (w_out_clear),
        .i_addr  (w_out_addr_d),
        .i_inst  (w_out_inst_d),
        .o_addr  (w_out_addr),
        .o_inst  (w_out_inst),
        .o_valid (w_out_valid)
    );

    if_id_entry #(.DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_addr  (bus.instAddrIn),
        .i_inst  (bus.instIn),
        .o_addr  (w_skid_addr),
        .o_inst  (w_skid_inst),
        .o_valid (w_skid_valid)
    );

    assign bus.instAddrOut = w_out_addr;
    assign bus.instOut     = w_out_inst;
    assign bus.validOut    = w_out_valid;
    assign dbgState        = occupancy(w_out_valid, w_skid_valid);

`ifdef IF_ID_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Both counters wrap freely; software takes differences.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_out_valid && !bus.readyIn) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flushIn) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stallCnt = r_stall_cnt;
    assign flushCnt = r_flush_cnt;
`else
    assign stallCnt = '0;
    assign flushCnt = '0;
`endif

endmodule

// File: tb/tb_if_id_buf.sv
// Directed bench for if_id_buf: reset, streaming, backpressure, flush, counters and wrap.
// Counter expectations follow IF_ID_PERF_CNT_EN; a 4-bit counter width makes the wrap reachable.
import if_id_buf_pkg::*;

module tb_if_id_buf;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
`ifdef IF_ID_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             flush_in;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    state_t           dbg_state;

    int n_checks;
    int n_fail;

    if_id_buf_if #(.DATA_W(DATA_W)) bus ();

    if_id_buf #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .flushIn  (flush_in),
        .stallCnt (stall_cnt),
        .flushCnt (flush_cnt),
        .dbgState (dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return addr ^ 32'h1234_5670;
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] addr, input logic rdy, input logic fl);
        bus.validIn    = v;
        bus.instAddrIn = addr;
        bus.instIn     = inst_of(addr);
        bus.readyIn    = rdy;
        flush_in       = fl;
    endtask

    task automatic expect_pair(input string tag, input logic [31:0] addr);
        check({tag, ".valid"}, 64'(bus.validOut), 64'd1);
        check({tag, ".addr"}, 64'(bus.instAddrOut), 64'(addr));
        check({tag, ".inst"}, 64'(bus.instOut), 64'(inst_of(addr)));
    endtask

    task automatic expect_bubble(input string tag);
        check({tag, ".valid"}, 64'(bus.validOut), 64'd0);
        check({tag, ".inst"}, 64'(bus.instOut), 64'h13);
    endtask

    task automatic expect_counters(input string tag, input int stalls, input int flushes);
        logic [CNT_W-1:0] es;
        logic [CNT_W-1:0] ef;
        es = PERF ? CNT_W'(stalls) : '0;
        ef = PERF ? CNT_W'(flushes) : '0;
        check({tag, ".stallCnt"}, 64'(stall_cnt), 64'(es));
        check({tag, ".flushCnt"}, 64'(flush_cnt), 64'(ef));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        expect_bubble("reset");
        check("reset.addr", 64'(bus.instAddrOut), 64'd0);
        check("reset.ready", 64'(bus.readyOut), 64'd1);
        check("reset.state", 64'(dbg_state), 64'(ST_EMPTY));
        expect_counters("reset", 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Streaming with decode always ready
        drive(1'b1, 32'h0, 1'b1, 1'b0); tick();
        expect_pair("stream0", 32'h0);
        check("stream0.ready", 64'(bus.readyOut), 64'd1);
        drive(1'b1, 32'h4, 1'b1, 1'b0); tick();
        expect_pair("stream1", 32'h4);
        drive(1'b1, 32'h8, 1'b1, 1'b0); tick();
        expect_pair("stream2", 32'h8);
        check("stream2.ready", 64'(bus.readyOut), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        expect_bubble("stream.drain");

        // Backpressure fills SKID, holds 0x18 upstream, then drains in order
        drive(1'b1, 32'h10, 1'b0, 1'b0); tick();
        expect_pair("bp.load10", 32'h10);
        check("bp.load10.ready", 64'(bus.readyOut), 64'd1);
        drive(1'b1, 32'h14, 1'b0, 1'b0); tick();
        expect_pair("bp.hold10a", 32'h10);
        check("bp.skid.ready", 64'(bus.readyOut), 64'd0);
        drive(1'b1, 32'h18, 1'b0, 1'b0); tick();
        expect_pair("bp.hold10b", 32'h10);
        check("bp.full.state", 64'(dbg_state), 64'(ST_FULL));
        check("bp.full.ready", 64'(bus.readyOut), 64'd0);
        drive(1'b1, 32'h18, 1'b1, 1'b0); tick();
        expect_pair("bp.out14", 32'h14);
        check("bp.out14.ready", 64'(bus.readyOut), 64'd1);
        drive(1'b1, 32'h18, 1'b1, 1'b0); tick();
        expect_pair("bp.out18", 32'h18);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        expect_bubble("bp.drain");
        expect_counters("bp", 2, 0);

        // Flush while FULL
        drive(1'b1, 32'h10, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h14, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
        check("fl.pre.state", 64'(dbg_state), 64'(ST_FULL));
        drive(1'b0, 32'h0, 1'b0, 1'b1); tick();
        expect_bubble("fl.full");
        check("fl.full.addr", 64'(bus.instAddrOut), 64'd0);
        check("fl.full.ready", 64'(bus.readyOut), 64'd1);
        check("fl.full.state", 64'(dbg_state), 64'(ST_EMPTY));
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        expect_bubble("fl.after");

        // Flush coincident with an accept drops the incoming pair
        drive(1'b1, 32'h20, 1'b1, 1'b1); tick();
        expect_bubble("fl.coinc");
        check("fl.coinc.ready", 64'(bus.readyOut), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        expect_bubble("fl.coinc.after");
        expect_counters("cnt", 5, 2);

        // Stall counter reaches all-ones, then wraps on one more stall
        drive(1'b1, 32'h30, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (10) tick();
        expect_counters("wrap.max", 15, 2);
        tick();
        expect_counters("wrap.zero", 16, 2);
        expect_pair("wrap.held30", 32'h30);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        expect_bubble("wrap.drain");

        // Reset in the middle of a backpressured stream
        drive(1'b1, 32'h40, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h44, 1'b0, 1'b0); tick();
        check("mid.pre.state", 64'(dbg_state), 64'(ST_FULL));
        #2 rst = 1'b0;
        #1;
        expect_bubble("mid.rst");
        check("mid.rst.addr", 64'(bus.instAddrOut), 64'd0);
        check("mid.rst.ready", 64'(bus.readyOut), 64'd1);
        check("mid.rst.state", 64'(dbg_state), 64'(ST_EMPTY));
        expect_counters("mid.rst", 0, 0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        expect_bubble("mid.after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
